alu_accumulator_seq: RTL and testbench

Sequencing and accumulator stage wrapped around the 3-bit combinational ALU. It accepts one operation request at a time and drives registered opcode/operand inputs into the ALU. It captures the ALU result into an accumulator that feeds back as operand A, and keeps carry, overflow and sticky-overflow flags plus an operation count. It sits directly upstream of the ALU inputs and directly downstream of its S/OV/Cout outputs.

---
 rtl/alu_accumulator_seq.sv | 93 +++++++++
 tb/tb_alu_accumulator_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator_seq.sv
// alu_accumulator_seq: sequences single ALU operations and accumulates the result.
// Operand A is fed back from the accumulator. Carry and overflow flags, a sticky
// overflow flag and a wrapping capture count are kept beside the accumulator.
module alu_accumulator_seq #(
    parameter int             W        = 3,
    parameter logic [W-1:0]   ACC_INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         load,
    input  logic [1:0]   op,
    input  logic [W-1:0] opnd,
    input  logic         clr_flags,
    output logic [1:0]   alu_ins,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_s,
    input  logic         alu_ov,
    input  logic         alu_cout,
    output logic [W-1:0] acc,
    output logic         cout_flag,
    output logic         ov_flag,
    output logic         ov_sticky,
    output logic         busy,
    output logic         done,
    output logic [3:0]   op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, nxt;

    // State register; reset wins over everything, including an EXEC capture.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state decode; start is only looked at in IDLE, never queued.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = load ? DONE : EXEC;
            EXEC:    nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Status outputs are pure state decodes, so inputs never reach them combinationally.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath: ALU input registers, accumulator, flags and capture counter.
    // alu_a follows every accumulator write so it always mirrors acc.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ins   <= 2'd0;
            alu_a     <= ACC_INIT;
            alu_b     <= '0;
            acc       <= ACC_INIT;
            cout_flag <= 1'b0;
            ov_flag   <= 1'b0;
            ov_sticky <= 1'b0;
            op_count  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && load) begin
                        acc   <= opnd;
                        alu_a <= opnd;
                    end else if (start) begin
                        alu_ins <= op;
                        alu_a   <= acc;
                        alu_b   <= opnd;
                    end
                end
                EXEC: begin
                    acc       <= alu_s;
                    alu_a     <= alu_s;
                    cout_flag <= alu_cout;
                    ov_flag   <= alu_ov;
                    op_count  <= op_count + 4'd1;
                end
                default: ;
            endcase
            // A captured overflow beats a simultaneous clear.
            ov_sticky <= (ov_sticky & ~clr_flags) | ((state == EXEC) & alu_ov);
        end
    end

endmodule

// File: tb/tb_alu_accumulator_seq.sv
// Directed-vector bench for alu_accumulator_seq with a 3-bit adder ALU model.
module tb_alu_accumulator_seq;

    localparam int          W        = 3;
    localparam logic [2:0]  ACC_INIT = 3'd5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         load = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] opnd = '0;
    logic         clr_flags = 1'b0;
    logic [1:0]   alu_ins;
    logic [W-1:0] alu_a, alu_b, alu_s;
    logic         alu_ov, alu_cout;
    logic [W-1:0] acc;
    logic         cout_flag, ov_flag, ov_sticky, busy, done;
    logic [3:0]   op_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_accumulator_seq #(.W(W), .ACC_INIT(ACC_INIT)) dut (
        .clk(clk), .reset(reset), .start(start), .load(load), .op(op), .opnd(opnd),
        .clr_flags(clr_flags), .alu_ins(alu_ins), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_ov(alu_ov), .alu_cout(alu_cout), .acc(acc),
        .cout_flag(cout_flag), .ov_flag(ov_flag), .ov_sticky(ov_sticky),
        .busy(busy), .done(done), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU model: 00 is add with carry and signed overflow; others are a plain AND.
    always_comb begin
        logic [3:0] sum;
        sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_s    = alu_a & alu_b;
        alu_cout = 1'b0;
        alu_ov   = 1'b0;
        if (alu_ins == 2'b00) begin
            alu_s    = sum[2:0];
            alu_cout = sum[3];
            alu_ov   = (alu_a[2] == alu_b[2]) && (sum[2] != alu_a[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 4) begin
            tick();
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b required 1", name, done);
        end
        tick();
    endtask

    task automatic do_load(input logic [2:0] v);
        start = 1'b1; load = 1'b1; opnd = v;
        tick();
        start = 1'b0; load = 1'b0;
        wait_done("load");
    endtask

    task automatic do_op(input logic [1:0] o, input logic [2:0] v);
        start = 1'b1; load = 1'b0; op = o; opnd = v;
        tick();
        start = 1'b0;
        wait_done("op");
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({acc, alu_a, alu_b, alu_ins} !== {ACC_INIT, ACC_INIT, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_data: acc=%0d a=%0d b=%0d ins=%0d required %0d %0d 0 0",
                     acc, alu_a, alu_b, alu_ins, ACC_INIT, ACC_INIT);
        end
        n_checks++;
        if ({cout_flag, ov_flag, ov_sticky, busy, done, op_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: c=%b ov=%b st=%b busy=%b done=%b cnt=%0d required all 0",
                     cout_flag, ov_flag, ov_sticky, busy, done, op_count);
        end
    endtask

    task automatic test_basic_add();
        do_load(3'd2);
        n_checks++;
        if (acc !== 3'd2 || op_count !== 4'd0) begin
            n_fail++;
            $display("FAIL load2: acc=%0d cnt=%0d required 2 0", acc, op_count);
        end
        start = 1'b1; op = 2'b00; opnd = 3'd1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, done, alu_ins, alu_a, alu_b} !== {1'b1, 1'b0, 2'b00, 3'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL exec_inputs: busy=%b done=%b ins=%0d a=%0d b=%0d required 1 0 0 2 1",
                     busy, done, alu_ins, alu_a, alu_b);
        end
        tick();
        n_checks++;
        if ({done, acc, cout_flag, ov_flag, op_count} !== {1'b1, 3'd3, 1'b0, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL add_2p1: done=%b acc=%0d c=%b ov=%b cnt=%0d required 1 3 0 0 1",
                     done, acc, cout_flag, ov_flag, op_count);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_overflow();
        do_op(2'b00, 3'd1);
        n_checks++;
        if ({acc, ov_flag, ov_sticky, cout_flag} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_3p1: acc=%0d ov=%b st=%b c=%b required 4 1 1 0",
                     acc, ov_flag, ov_sticky, cout_flag);
        end
        do_op(2'b00, 3'd0);
        n_checks++;
        if ({acc, ov_flag, ov_sticky} !== {3'd4, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sticky_hold: acc=%0d ov=%b st=%b required 4 0 1", acc, ov_flag, ov_sticky);
        end
    endtask

    task automatic test_carry();
        do_load(3'd7);
        do_op(2'b00, 3'd1);
        n_checks++;
        if ({acc, cout_flag, ov_flag} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL carry_7p1: acc=%0d c=%b ov=%b required 0 1 0", acc, cout_flag, ov_flag);
        end
    endtask

    task automatic test_ignore_start();
        logic [3:0] cnt0;
        int pulses;
        cnt0 = op_count;
        pulses = 0;
        start = 1'b1; load = 1'b0; op = 2'b00; opnd = 3'd1;
        tick();                                  // EXEC; start still high
        tick();                                  // DONE; start still high
        if (done) pulses++;
        tick();                                  // back to IDLE
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 1 || op_count !== cnt0 + 4'd1) begin
            n_fail++;
            $display("FAIL ignore_start: pulses=%0d cnt=%0d required 1 %0d", pulses, op_count, cnt0 + 4'd1);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) do_op(2'b00, 3'd0);
        n_checks++;
        if (op_count !== 4'd15) begin
            n_fail++;
            $display("FAIL count_15: cnt=%0d required 15", op_count);
        end
        do_op(2'b00, 3'd0);
        n_checks++;
        if (op_count !== 4'd0) begin
            n_fail++;
            $display("FAIL count_wrap: cnt=%0d required 0", op_count);
        end
    endtask

    task automatic test_reset_in_exec();
        int pulses;
        pulses = 0;
        do_load(3'd3);
        do_op(2'b00, 3'd1);                      // sets ov_flag/ov_sticky
        start = 1'b1; op = 2'b00; opnd = 3'd1;
        tick();                                  // in EXEC
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (done) pulses++;
        n_checks++;
        if ({acc, busy, done, cout_flag, ov_flag, ov_sticky, op_count} !==
            {ACC_INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_exec: acc=%0d busy=%b done=%b c=%b ov=%b st=%b cnt=%0d required %0d 0 0 0 0 0 0",
                     acc, busy, done, cout_flag, ov_flag, ov_sticky, op_count, ACC_INIT);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_exec_done: pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_clr_flags();
        do_reset();
        do_load(3'd3);
        start = 1'b1; op = 2'b00; opnd = 3'd1;
        tick();                                  // in EXEC
        start = 1'b0;
        clr_flags = 1'b1;
        tick();                                  // capture with ov=1 and clear together
        clr_flags = 1'b0;
        n_checks++;
        if (ov_sticky !== 1'b1 || acc !== 3'd4) begin
            n_fail++;
            $display("FAIL clr_vs_set: st=%b acc=%0d required 1 4", ov_sticky, acc);
        end
        tick();                                  // IDLE
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        n_checks++;
        if ({ov_sticky, acc, ov_flag} !== {1'b0, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_idle: st=%b acc=%0d ov=%b required 0 4 1", ov_sticky, acc, ov_flag);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_overflow();
        test_carry();
        test_ignore_start();
        test_count_wrap();
        test_reset_in_exec();
        test_clr_flags();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
